seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Receiving end of the multiplexed 4-digit seven-segment interface: samples a scanned
//  seg/anode bus and rebuilds the four displayed hex nibbles, one frame at a time.
//  Used as a loop-back checker for the display path and as a capture front end when
//  another board drives the display bus.
// PARAMETERS
//  SETTLE_CYCLES   4        cycles the anode must hold (>=1) before segments are sampled
//  TIMEOUT_CYCLES  1000000  cycles with no anode change before stall is flagged
//  (localparam CNT_W = $clog2(TIMEOUT_CYCLES+1); one counter serves both settle and timeout)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  seg_in       in   8   {dp,g,f,e,d,c,b,a}, active-low; already synchronous to clk
//  anode_in     in   4   digit enables, active-low; exactly one low is legal
//  digits_out   out  16  digit3..digit0 nibbles; anode_in[i] low -> bits [4i+3:4i]
//  frame_valid  out  1   one-cycle pulse: digits_out/frame_err updated this cycle
//  frame_err    out  1   the frame just presented had >=1 undecodable pattern
//  stall        out  1   high while scan is stopped for >= TIMEOUT_CYCLES
//  dp_out       out  4   decimal-point capture per digit (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: digits_out=0, frame_valid=0, frame_err=0, stall=0, dp_out=0,
//    counter=0, capture mask=0, state=IDLE. Any reset mid-frame discards the partial frame.
//  Legal anode = exactly one bit low. Inputs are registered once (anode_q) before use.
//  FSM:
//    IDLE    : anode_q illegal. Legal anode -> SETTLE, counter=1.
//    SETTLE  : counter++ each cycle the anode is unchanged; when it reaches SETTLE_CYCLES,
//              sample seg_q and go to HOLD. Any change -> restart SETTLE (counter=1),
//              or IDLE if illegal. A change in the same cycle the count is reached
//              wins: no sample.
//    HOLD    : wait for the anode to change (-> SETTLE or IDLE). Resampling is forbidden.
//  Sample: decode seg_q[6:0] via the package table. Write the nibble to the digit slot
//    selected by anode_q and set that mask bit. A non-matching pattern stores 4'h0 and
//    sets the frame error accumulator. Recapturing an already-masked digit overwrites it.
//  Frame: in the cycle after the sample that makes mask==4'hF: frame_valid=1,
//    digits_out/frame_err load from the slot and accumulator registers, and the mask and
//    accumulator clear. digits_out holds between frames.
//  Timeout: counter keeps running (saturating at TIMEOUT_CYCLES) in HOLD/IDLE. At
//    TIMEOUT_CYCLES: stall=1, mask and accumulator clear. stall drops in the cycle after
//    the next anode_q change.
//  Latency: anode change at input -> sample after 1 (sync) + SETTLE_CYCLES cycles;
//    frame_valid 1 cycle after the 4th sample.
//  Decode table (gfedcba, active-low), 0..F:
//    40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
// CONFIGURATION
//  SEG_DP_CAPTURE_EN defined: dp_out[i] = ~seg_q[7] at digit i's sample, presented with
//    frame_valid alongside digits_out.
//  SEG_DP_CAPTURE_EN undefined: dp_out tied 4'b0000, seg_in[7] ignored, no dp registers.
// STRUCTURE
//  Shared package seg_pkg: the 16-entry 7-bit segment table, the segment bit-position
//    constants, and FSM state encodings IDLE/SETTLE/HOLD.
//  Sub-module seg7_to_hex (combinational: pattern -> {valid, nibble}), instantiated once.
// TESTING
//  1. Scan 0,1,2,3 on anodes E,D,B,7, each held 10 cycles, SETTLE=4 -> frame_valid
//     pulse once; digits_out=16'h3210, frame_err=0.
//  2. Digit 2 pattern 7'h7F (blank) in an otherwise legal scan -> digits_out[11:8]=0,
//     frame_err=1; next clean frame has frame_err=0.
//  3. Anode held for only 3 cycles (SETTLE=4) -> no capture of that digit; frame
//     completes only after a full-length revisit.
//  4. anode_in=4'b1100 or 4'hF between digits -> ignored; no write, FSM to IDLE,
//     values unchanged.
//  5. Stop the scan after 2 digits, TIMEOUT=50 -> stall=1 at cycle 50; resume with a
//     full scan -> stall=0, frame holds only the new digits.
//  6. rst pulse after 3 digits -> all outputs 0; the next 4-digit scan gives one frame.
//     With SEG_DP_CAPTURE_EN, dp lit on digit 1 -> dp_out=4'b0010.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment bit positions,
// the hex glyph table (gfedcba, active-low) and scan FSM states.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry k is the active-low glyph for hex digit k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  function automatic logic anode_legal(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] anode_idx(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    case (a)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: active-low gfedcba pattern -> {valid, hex nibble}.
// Patterns outside the table report valid=0 with nibble 0.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_valid,
  output logic [3:0] o_nib
);

  always_comb begin
    o_valid = 1'b0;
    o_nib   = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (i_pat == SEG_TABLE[k]) begin
        o_valid = 1'b1;
        o_nib   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds four hex digits from a scanned, active-low seg/anode display bus.
// Optional decimal-point capture is enabled by defining SEG_DP_CAPTURE_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  anode_in,
  output logic [15:0] digits_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stall,
  output logic [3:0]  dp_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  logic [3:0]       r_anode_q, r_anode_d;
  logic [6:0]       r_seg_q;
  scan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0][3:0]  r_slot;
  logic [3:0]       r_mask;
  logic             r_acc;
  logic [15:0]      r_digits;
  logic             r_fv, r_ferr, r_stall;

  scan_state_e      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt, w_cnt_inc;
  logic             w_changed, w_legal, w_sample, w_to_hit, w_frame;
  logic [1:0]       w_idx;
  logic             w_dec_valid;
  logic [3:0]       w_dec_nib;

  assign w_changed = (r_anode_q != r_anode_d);
  assign w_legal   = anode_legal(r_anode_q);
  assign w_idx     = anode_idx(r_anode_q);
  assign w_frame   = (r_mask == 4'hF);
  assign w_cnt_inc = (r_cnt == TIMEOUT_C) ? r_cnt : r_cnt + CNT_W'(1);

  seg7_to_hex u_dec (
    .i_pat   (r_seg_q),
    .o_valid (w_dec_valid),
    .o_nib   (w_dec_nib)
  );

  // The counter measures cycles since the last anode change; SETTLE reuses it
  // for settling, HOLD/IDLE let it run on toward the stall threshold.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_sample    = 1'b0;
    if (w_changed) begin
      w_cnt_nxt   = CNT_W'(1);
      w_state_nxt = w_legal ? ST_SETTLE : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt >= SETTLE_C) begin
            w_sample    = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_to_hit = (w_cnt_nxt == TIMEOUT_C) && (r_cnt != TIMEOUT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode_q <= 4'hF;
      r_anode_d <= 4'hF;
      r_seg_q   <= 7'h7F;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
    end else begin
      r_anode_q <= anode_in;
      r_anode_d <= r_anode_q;
      r_seg_q   <= seg_in[SEG_G:SEG_A];
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot   <= '0;
      r_mask   <= '0;
      r_acc    <= 1'b0;
      r_digits <= '0;
      r_fv     <= 1'b0;
      r_ferr   <= 1'b0;
      r_stall  <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      if (w_changed)     r_stall <= 1'b0;
      else if (w_to_hit) r_stall <= 1'b1;

      if (w_frame) begin
        r_digits <= r_slot;
        r_ferr   <= r_acc;
        r_fv     <= 1'b1;
        r_mask   <= '0;
        r_acc    <= 1'b0;
      end else if (w_to_hit) begin
        r_mask <= '0;
        r_acc  <= 1'b0;
      end

      // Sample last so a capture is never lost to a same-cycle clear.
      if (w_sample) begin
        r_slot[w_idx] <= w_dec_valid ? w_dec_nib : 4'h0;
        r_mask[w_idx] <= 1'b1;
        if (!w_dec_valid) r_acc <= 1'b1;
      end
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  logic       r_seg_dp;
  logic [3:0] r_dp_slot, r_dp_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_dp  <= 1'b1;
      r_dp_slot <= '0;
      r_dp_out  <= '0;
    end else begin
      r_seg_dp <= seg_in[SEG_DP];
      if (w_frame)  r_dp_out <= r_dp_slot;
      if (w_sample) r_dp_slot[w_idx] <= ~r_seg_dp;
    end
  end

  assign dp_out = r_dp_out;
`else
  logic w_unused_dp;
  assign w_unused_dp = seg_in[SEG_DP];
  assign dp_out      = 4'b0000;
`endif

  assign digits_out  = r_digits;
  assign frame_valid = r_fv;
  assign frame_err   = r_ferr;
  assign stall       = r_stall;

endmodule
